// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator to its consumers.
// master drives the counters, syncs and event pulses; slave observes them.
interface vga_sync_gen_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_end;
  logic       frame_start;
  logic       vblank_start;
  logic [7:0] frame_count;

  modport master (
    output hcount, vcount, hsync, vsync, video_on,
    output line_end, frame_start, vblank_start, frame_count
  );

  modport slave (
    input hcount, vcount, hsync, vsync, video_on,
    input line_end, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster counters, phase FSMs and aligned strobes.
// Define VGA_FRAME_COUNT_EN to add the 8-bit completed-frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           pxl_clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_AT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYN_AT = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_AT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_AT = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] H_ACT   = 2'd0;
  localparam logic [1:0] H_FRONT = 2'd1;
  localparam logic [1:0] H_SYN   = 2'd2;
  localparam logic [1:0] H_BACK  = 2'd3;
  localparam logic [1:0] V_ACT   = 2'd0;
  localparam logic [1:0] V_FRONT = 2'd1;
  localparam logic [1:0] V_SYN   = 2'd2;
  localparam logic [1:0] V_BACK  = 2'd3;

  logic [9:0] hcount, vcount;
  logic [9:0] h_nxt, v_nxt;
  logic [1:0] hphase, vphase;
  logic [1:0] hphase_nxt, vphase_nxt;
  logic       h_wrap, v_wrap;
  logic       hsync_q, vsync_q, video_q;
  logic       line_q, frame_q, vblank_q;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : hcount + 10'd1;
    v_nxt  = vcount;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : vcount + 10'd1;
  end

  always_comb begin
    hphase_nxt = hphase;
    unique case (hphase)
      H_ACT:   if (h_nxt == H_FP_AT)  hphase_nxt = H_FRONT;
      H_FRONT: if (h_nxt == H_SYN_AT) hphase_nxt = H_SYN;
      H_SYN:   if (h_nxt == H_BP_AT)  hphase_nxt = H_BACK;
      H_BACK:  if (h_wrap)            hphase_nxt = H_ACT;
      default: hphase_nxt = H_ACT;
    endcase
  end

  always_comb begin
    vphase_nxt = vphase;
    unique case (vphase)
      V_ACT:   if (h_wrap && v_nxt == V_FP_AT)  vphase_nxt = V_FRONT;
      V_FRONT: if (h_wrap && v_nxt == V_SYN_AT) vphase_nxt = V_SYN;
      V_SYN:   if (h_wrap && v_nxt == V_BP_AT)  vphase_nxt = V_BACK;
      V_BACK:  if (h_wrap && v_wrap)            vphase_nxt = V_ACT;
      default: vphase_nxt = V_ACT;
    endcase
  end

  // Strobes come from the next count so they line up with the count they describe.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      hcount   <= '0;
      vcount   <= '0;
      hphase   <= H_ACT;
      vphase   <= V_ACT;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      video_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      hcount   <= h_nxt;
      vcount   <= v_nxt;
      hphase   <= hphase_nxt;
      vphase   <= vphase_nxt;
      hsync_q  <= (hphase_nxt != H_SYN);
      vsync_q  <= (vphase_nxt != V_SYN);
      video_q  <= (hphase_nxt == H_ACT) && (vphase_nxt == V_ACT);
      line_q   <= (h_nxt == H_LAST);
      frame_q  <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      vblank_q <= (h_nxt == 10'd0) && (v_nxt == V_FP_AT);
    end
  end

  assign vga.hcount       = hcount;
  assign vga.vcount       = vcount;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_on     = video_q;
  assign vga.line_end     = line_q;
  assign vga.frame_start  = frame_q;
  assign vga.vblank_start = vblank_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst)                  frame_cnt <= '0;
    else if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end

  assign vga.frame_count = frame_cnt;
`else
  assign vga.frame_count = 8'd0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size and shrunken raster generators checked per cycle
// against an arithmetic position model (cycle index -> pixel, line, frame).
module tb_vga_sync_gen;
  localparam int SHA = 8, SHFP = 2, SHS = 3, SHBP = 2;
  localparam int SVA = 6, SVFP = 1, SVS = 2, SVBP = 1;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;
  localparam int SF  = SHT * SVT;
  localparam int FHT = 800;

  logic pxl_clk = 1'b0;
  logic rst = 1'b1;
  int   t = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 pxl_clk = ~pxl_clk;

  vga_sync_gen_if fif();
  vga_sync_gen_if sif();

  vga_sync_gen dut_full (
    .pxl_clk (pxl_clk),
    .rst     (rst),
    .vga     (fif.master)
  );

  vga_sync_gen #(
    .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
    .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
  ) dut_small (
    .pxl_clk (pxl_clk),
    .rst     (rst),
    .vga     (sif.master)
  );

  logic [35:0] obs_f, obs_s;
  assign obs_f = {fif.hcount, fif.vcount, fif.hsync, fif.vsync,
                  fif.video_on, fif.line_end, fif.frame_start,
                  fif.vblank_start, fif.frame_count};
  assign obs_s = {sif.hcount, sif.vcount, sif.hsync, sif.vsync,
                  sif.video_on, sif.line_end, sif.frame_start,
                  sif.vblank_start, sif.frame_count};

  // t = rising edges since reset released; t==0 is the reset state.
  function automatic logic [35:0] exp_vec(input int tt,
      input int ha, input int hfp, input int hs, input int hbp,
      input int va, input int vfp, input int vs, input int vbp);
    int ht, vt, f, p, h, v;
    logic [7:0] fc;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    f  = ht * vt;
    p  = tt % f;
    h  = p % ht;
    v  = p / ht;
`ifdef VGA_FRAME_COUNT_EN
    fc = 8'((tt / f) % 256);
`else
    fc = 8'd0;
`endif
    return {10'(h), 10'(v),
            !(h >= ha + hfp && h < ha + hfp + hs),
            !(v >= va + vfp && v < va + vfp + vs),
            (tt != 0) && (h < ha) && (v < va),
            h == ht - 1,
            (tt != 0) && (p == 0),
            (h == 0) && (v == va),
            fc};
  endfunction

  function automatic logic [35:0] exp_full(input int tt);
    return exp_vec(tt, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [35:0] exp_small(input int tt);
    return exp_vec(tt, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP);
  endfunction

  task automatic step();
    @(posedge pxl_clk);
    #1;
    if (!rst) t++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    t = 0;
    repeat (5) step();
    checks++;
    if (obs_f !== exp_full(0)) begin
      errors++;
      $display("FAIL reset_full got %h exp %h", obs_f, exp_full(0));
    end
    checks++;
    if (obs_s !== exp_small(0)) begin
      errors++;
      $display("FAIL reset_small got %h exp %h", obs_s, exp_small(0));
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs_f !== exp_full(t) || fif.hcount !== 10'd1 || fif.video_on !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_full got %h exp %h", obs_f, exp_full(t));
    end
    checks++;
    if (obs_s !== exp_small(t)) begin
      errors++;
      $display("FAIL first_edge_small got %h exp %h", obs_s, exp_small(t));
    end
  endtask

  task automatic test_line_timing();
    int low_cnt, low_start, le_cnt, le_at;
    logic prev_hs, prev_le;
    low_cnt = 0; low_start = -1; le_cnt = 0; le_at = -1;
    prev_hs = fif.hsync; prev_le = fif.line_end;
    for (int i = 0; i < FHT; i++) begin
      step();
      checks++;
      if (obs_f !== exp_full(t)) begin
        errors++;
        $display("FAIL line_full t=%0d got %h exp %h", t, obs_f, exp_full(t));
      end
      if (!fif.hsync) low_cnt++;
      if (prev_hs && !fif.hsync) low_start = int'(fif.hcount);
      if (fif.line_end) begin le_cnt++; le_at = int'(fif.hcount); end
      if (prev_le) begin
        checks++;
        if (fif.hcount !== 10'd0 || fif.vcount !== 10'd1) begin
          errors++;
          $display("FAIL after_line_end got %0d,%0d exp 0,1", fif.hcount, fif.vcount);
        end
      end
      prev_hs = fif.hsync;
      prev_le = fif.line_end;
    end
    checks++;
    if (low_cnt != 96 || low_start != 656) begin
      errors++;
      $display("FAIL hsync_window got len %0d start %0d exp 96 656", low_cnt, low_start);
    end
    checks++;
    if (le_cnt != 1 || le_at != 799) begin
      errors++;
      $display("FAIL line_end_once got %0d at %0d exp 1 at 799", le_cnt, le_at);
    end
  endtask

  task automatic test_frame();
    int vs_low, vb_cnt, vid_bad;
    vs_low = 0; vb_cnt = 0; vid_bad = 0;
    for (int i = 0; i < SF; i++) begin
      step();
      checks++;
      if (obs_s !== exp_small(t)) begin
        errors++;
        $display("FAIL frame_small t=%0d got %h exp %h", t, obs_s, exp_small(t));
      end
      if (!sif.vsync) vs_low++;
      if (sif.vblank_start) vb_cnt++;
      if (sif.video_on && sif.vcount >= 10'(SVA)) vid_bad++;
    end
    checks++;
    if (vs_low != SHT * SVS) begin
      errors++;
      $display("FAIL vsync_len got %0d exp %0d", vs_low, SHT * SVS);
    end
    checks++;
    if (vb_cnt != 1 || vid_bad != 0) begin
      errors++;
      $display("FAIL vblank got pulses %0d video_bad %0d exp 1 0", vb_cnt, vid_bad);
    end
  endtask

  task automatic test_wrap();
    int t0, t1;
    logic prev_le;
    t0 = -1; t1 = -1;
    prev_le = sif.line_end;
    for (int i = 0; i < 3 * SF && t1 < 0; i++) begin
      step();
      checks++;
      if (obs_s !== exp_small(t)) begin
        errors++;
        $display("FAIL wrap_small t=%0d got %h exp %h", t, obs_s, exp_small(t));
      end
      if (sif.frame_start) begin
        checks++;
        if (!prev_le || sif.hcount !== 10'd0 || sif.vcount !== 10'd0) begin
          errors++;
          $display("FAIL wrap_seq got le %b pos %0d,%0d exp 1 0,0",
                   prev_le, sif.hcount, sif.vcount);
        end
        if (t0 < 0) t0 = t;
        else t1 = t;
      end
      prev_le = sif.line_end;
    end
    checks++;
    if (t1 - t0 != SF || t0 < 0) begin
      errors++;
      $display("FAIL frame_period got %0d exp %0d", t1 - t0, SF);
    end
  endtask

  task automatic test_midframe_reset();
    for (int it = 0; it < 4; it++) begin
      int th, tv;
      bit found;
      th = int'($urandom_range(SHT - 1, 0));
      tv = SVA + SVFP + int'($urandom_range(SVS - 1, 0));
      found = 1'b0;
      for (int i = 0; i < 2 * SF + 2 * FHT && !found; i++) begin
        step();
        checks++;
        if (obs_s !== exp_small(t) || obs_f !== exp_full(t)) begin
          errors++;
          $display("FAIL pre_reset t=%0d got %h %h exp %h %h",
                   t, obs_s, obs_f, exp_small(t), exp_full(t));
        end
        if (it == 0) found = (fif.hcount == 10'd700);
        else found = (sif.hcount == 10'(th) && sif.vcount == 10'(tv));
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL reset_target timeout got %0d,%0d exp %0d,%0d",
                 sif.hcount, sif.vcount, th, tv);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs_s !== exp_small(0) || obs_f !== exp_full(0)) begin
        errors++;
        $display("FAIL async_reset got %h %h exp %h %h",
                 obs_s, obs_f, exp_small(0), exp_full(0));
      end
      t = 0;
      repeat (int'($urandom_range(3, 1))) step();
      checks++;
      if (obs_s !== exp_small(0) || obs_f !== exp_full(0)) begin
        errors++;
        $display("FAIL reset_hold got %h %h exp %h %h",
                 obs_s, obs_f, exp_small(0), exp_full(0));
      end
      rst = 1'b0;
      step();
      checks++;
      if (obs_s !== exp_small(t) || obs_f !== exp_full(t)) begin
        errors++;
        $display("FAIL restart got %h %h exp %h %h",
                 obs_s, obs_f, exp_small(t), exp_full(t));
      end
    end
  endtask

  task automatic test_frame_count();
    logic [7:0] seen[$];
    rst = 1'b1;
    step();
    t = 0;
    rst = 1'b0;
    for (int i = 0; i < 257 * SF; i++) begin
      step();
      checks++;
      if (obs_s !== exp_small(t)) begin
        errors++;
        $display("FAIL fc_small t=%0d got %h exp %h", t, obs_s, exp_small(t));
      end
      if (sif.frame_start) seen.push_back(sif.frame_count);
    end
    checks++;
    if (seen.size() != 257) begin
      errors++;
      $display("FAIL fc_pulses got %0d exp 257", seen.size());
    end
    for (int k = 0; k < seen.size(); k++) begin
      logic [7:0] want;
`ifdef VGA_FRAME_COUNT_EN
      want = 8'((k + 1) % 256);
`else
      want = 8'd0;
`endif
      checks++;
      if (seen[k] !== want) begin
        errors++;
        $display("FAIL fc_seq k=%0d got %0d exp %0d", k, seen[k], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_wrap();
    test_midframe_reset();
    test_frame_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
